// File: rtl/spart_pkg.sv
// Shared SPART constants: data width and default receive FIFO depth.
package spart_pkg;
  localparam int DATA_W            = 8;
  localparam int RX_FIFO_DEPTH_DEF = 16;

  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/rx_fifo_mem.sv
// Byte storage for rx_fifo: synchronous write, asynchronous read at raddr, no reset.
module rx_fifo_mem
  import spart_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  data_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_fifo.sv
// Receive byte FIFO between the SPART receiver and the CPU; full/empty/count come from registered state.
// Optional overrun flag (ovr/clr_ovr) is built when RX_FIFO_OVR_FLAG_EN is defined.
module rx_fifo
  import spart_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] RxD_data,
  input  logic              RDA,
  output logic              rd_rx,
  input  logic              cpu_rd,
`ifdef RX_FIFO_OVR_FLAG_EN
  input  logic              clr_ovr,
  output logic              ovr,
`endif
  output logic [DATA_W-1:0] cpu_data,
  output logic              data_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_rx_q, taken_q, taken_d, dv_q;
  data_t             cpu_data_q, cpu_data_d, mem_rdata;
  logic              wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // taken_q marks a held RDA byte as already stored until the receiver drops RDA.
  assign wr_en = RDA && !full && !rd_rx_q && !taken_q;
  assign rd_en = cpu_rd && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cpu_data_d = cpu_data_q;
    taken_d    = taken_q && RDA;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      taken_d  = 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
      cpu_data_d = mem_rdata;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_rx_q    <= 1'b0;
      taken_q    <= 1'b0;
      dv_q       <= 1'b0;
      cpu_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_rx_q    <= wr_en;
      taken_q    <= taken_d;
      dv_q       <= rd_en;
      cpu_data_q <= cpu_data_d;
    end
  end

`ifdef RX_FIFO_OVR_FLAG_EN
  logic ovr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ovr_q <= 1'b0;
    else if (clr_ovr)     ovr_q <= 1'b0;
    else if (RDA && full) ovr_q <= 1'b1;
  end
  assign ovr = ovr_q;
`endif

  rx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (RxD_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign rd_rx      = rd_rx_q;
  assign cpu_data   = cpu_data_q;
  assign data_valid = dv_q;
  assign count      = count_q;

endmodule

// File: tb/tb_rx_fifo.sv
// Directed self-checking bench for rx_fifo; overrun checks compile in with RX_FIFO_OVR_FLAG_EN.
module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] RxD_data;
  logic       RDA;
  logic       rd_rx;
  logic       cpu_rd;
  logic [7:0] cpu_data;
  logic       data_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
`ifdef RX_FIFO_OVR_FLAG_EN
  logic       clr_ovr;
  logic       ovr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .RxD_data   (RxD_data),
    .RDA        (RDA),
    .rd_rx      (rd_rx),
    .cpu_rd     (cpu_rd),
`ifdef RX_FIFO_OVR_FLAG_EN
    .clr_ovr    (clr_ovr),
    .ovr        (ovr),
`endif
    .cpu_data   (cpu_data),
    .data_valid (data_valid),
    .empty      (empty),
    .full       (full),
    .count      (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte written with RDA dropped afterwards, as the receiver would.
  task automatic push(input logic [7:0] b);
    RxD_data = b;
    RDA      = 1'b1;
    tick();
    chk("push_ack", rd_rx, 1);
    RDA = 1'b0;
    tick();
  endtask

  task automatic pop(input string tag, input logic [7:0] b);
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    chk({tag, "_dv"}, data_valid, 1);
    chk({tag, "_data"}, cpu_data, b);
  endtask

  initial begin
    int pulses;
    logic [7:0] b;
    rst = 1'b1; RDA = 1'b0; RxD_data = 8'h00; cpu_rd = 1'b0;
`ifdef RX_FIFO_OVR_FLAG_EN
    clr_ovr = 1'b0;
`endif
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_rx", rd_rx, 0);
    chk("rst_cpu_data", cpu_data, 8'h00);
    chk("rst_dv", data_valid, 0);
`ifdef RX_FIFO_OVR_FLAG_EN
    chk("rst_ovr", ovr, 0);
`endif
    rst = 1'b0;
    tick();

    // Single byte round trip
    RxD_data = 8'hA5; RDA = 1'b1;
    tick();
    chk("a5_rd_rx", rd_rx, 1);
    chk("a5_count", count, 1);
    chk("a5_empty", empty, 0);
    RDA = 1'b0;
    tick();
    chk("a5_rd_rx_pulse", rd_rx, 0);
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    chk("a5_data", cpu_data, 8'hA5);
    chk("a5_dv", data_valid, 1);
    chk("a5_count0", count, 0);
    tick();
    chk("a5_dv_pulse", data_valid, 0);

    // Held RDA stored once
    RxD_data = 8'h3C; RDA = 1'b1; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rd_rx) pulses++;
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_count", count, 1);
    RDA = 1'b0;
    tick();
    pop("hold_pop", 8'h3C);
    chk("hold_count0", count, 0);

    // Fill, stall on full, read releases the pending byte
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    RxD_data = 8'hFF; RDA = 1'b1;
    tick();
    chk("stall_rd_rx", rd_rx, 0);
    chk("stall_count", count, 16);
`ifdef RX_FIFO_OVR_FLAG_EN
    chk("stall_ovr", ovr, 1);
`endif
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    chk("full_rd_data", cpu_data, 8'h00);
    chk("full_rd_rd_rx", rd_rx, 0);
    chk("full_rd_count", count, 15);
    tick();
    chk("late_wr_rd_rx", rd_rx, 1);
    chk("late_wr_count", count, 16);
    RDA = 1'b0;
    cpu_rd = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      b = (i == 16) ? 8'hFF : 8'(i);
      chk("drain_data", cpu_data, b);
      chk("drain_dv", data_valid, 1);
    end
    cpu_rd = 1'b0;
    tick();
    chk("drain_empty", empty, 1);
    chk("drain_dv0", data_valid, 0);
`ifdef RX_FIFO_OVR_FLAG_EN
    RDA = 1'b1;
    for (int i = 0; i < 16; i++) begin
      RxD_data = 8'(i); tick(); RDA = 1'b0; tick(); RDA = 1'b1;
    end
    clr_ovr = 1'b1;
    tick();
    chk("ovr_clr_wins", ovr, 0);
    clr_ovr = 1'b0;
    RDA = 1'b0;
    cpu_rd = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    cpu_rd = 1'b0;
    tick();
    chk("ovr_drain_empty", empty, 1);
`endif

    // Simultaneous write and read at count 4
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    chk("c4_count", count, 4);
    RxD_data = 8'h14; RDA = 1'b1; cpu_rd = 1'b1;
    tick();
    RDA = 1'b0; cpu_rd = 1'b0;
    chk("c4_count_same", count, 4);
    chk("c4_oldest", cpu_data, 8'h10);
    chk("c4_rd_rx", rd_rx, 1);
    tick();
    pop("c4_p1", 8'h11);
    pop("c4_p2", 8'h12);
    pop("c4_p3", 8'h13);
    pop("c4_p4", 8'h14);
    chk("c4_empty", empty, 1);

    // Read while empty is ignored
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    chk("empty_rd_dv", data_valid, 0);
    chk("empty_rd_data", cpu_data, 8'h14);
    chk("empty_rd_count", count, 0);

    // 40 write/read pairs across pointer wrap
    for (int i = 0; i < 40; i++) begin
      b = 8'(i * 7 + 3);
      RxD_data = b; RDA = 1'b1;
      tick();
      RDA = 1'b0;
      pop("wrap", b);
      chk("wrap_count", count, 0);
    end

    // Reset mid-operation with a held RDA
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    RxD_data = 8'h26; RDA = 1'b1;
    tick();
    chk("pre_rst_count", count, 7);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_rd_rx", rd_rx, 0);
    chk("mid_rst_cpu_data", cpu_data, 8'h00);
    #1;
    rst = 1'b0;
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    chk("post_rst_rd_ignored", data_valid, 0);
    chk("post_rst_ack", rd_rx, 1);
    chk("post_rst_count", count, 1);
    RDA = 1'b0;
    tick();
    pop("post_rst_pop", 8'h26);
    chk("post_rst_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
